// File: rtl/bp_network_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_network_pkg
// Brief    : Types and helpers shared by the network serializer and deserializer.
// Revision : 1.0  initial release
// ============================================================================

// Flit layout: destination ID in the upper bits, payload chunk in the lower bits.
`define BP_NETWORK_FLIT_S(dest_width, data_width) \
    typedef struct packed { \
        logic [dest_width-1:0] dest_id; \
        logic [data_width-1:0] data; \
    } bp_network_flit_s

package bp_network_pkg;

    typedef enum logic [0:0] {
        eIdle = 1'b0,
        eSend = 1'b1
    } bp_network_serializer_state_e;

    // Flits per message; both ends of the link call this so they always agree.
    function automatic int bp_network_num_packets(input int source_width, input int packet_width);
        return (source_width + packet_width - 1) / packet_width;
    endfunction

    function automatic int bp_network_count_width(input int num_packets);
        return (num_packets > 1) ? $clog2(num_packets) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_network_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : bp_network_serializer_if
// Brief    : Message-in / flit-out handshake bundle of the network serializer.
//            last_o exists only when BP_NETWORK_SERIALIZER_LAST_FLIT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
interface bp_network_serializer_if #(
    parameter int DEST_ID_WIDTH     = 4,
    parameter int SOURCE_DATA_WIDTH = 64,
    parameter int PACKET_DATA_WIDTH = 16
);
    localparam int FLIT_WIDTH = PACKET_DATA_WIDTH + DEST_ID_WIDTH;

    logic                         v_i;
    logic                         ready_o;
    logic [DEST_ID_WIDTH-1:0]     dest_id_i;
    logic [SOURCE_DATA_WIDTH-1:0] data_i;
    logic                         v_o;
    logic [FLIT_WIDTH-1:0]        data_o;
    logic                         ready_i;
`ifdef BP_NETWORK_SERIALIZER_LAST_FLIT_EN
    logic                         last_o;
`endif

    // master: message source plus flit sink; slave: the serializer itself
    modport master (
        output v_i, dest_id_i, data_i, ready_i,
        input  ready_o, v_o, data_o
`ifdef BP_NETWORK_SERIALIZER_LAST_FLIT_EN
        , input last_o
`endif
    );

    modport slave (
        input  v_i, dest_id_i, data_i, ready_i,
        output ready_o, v_o, data_o
`ifdef BP_NETWORK_SERIALIZER_LAST_FLIT_EN
        , output last_o
`endif
    );

endinterface

`default_nettype wire

// File: rtl/bsg_counter_clear_up.sv
`default_nettype none
// ============================================================================
// Module   : bsg_counter_clear_up
// Brief    : Wrapping up-counter with synchronous clear; clear beats up.
// Revision : 1.0  initial release
// ============================================================================
module bsg_counter_clear_up #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_clear,
    input  wire logic             i_up,
    output logic [WIDTH-1:0]      o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_up) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/bp_network_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bp_network_serializer
// Brief    : Splits one {dest_id, payload} message into a train of dest-tagged
//            flits, least significant chunk first. Optional last_o under
//            BP_NETWORK_SERIALIZER_LAST_FLIT_EN.
// Revision : 1.0  initial release
// ============================================================================
module bp_network_serializer
    import bp_network_pkg::*;
#(
    parameter int DEST_ID_WIDTH     = 4,
    parameter int SOURCE_DATA_WIDTH = 64,
    parameter int PACKET_DATA_WIDTH = 16
) (
    input wire logic clk_i,
    input wire logic reset_i,
    bp_network_serializer_if.slave bus
);

    localparam int NUM_PACKETS = bp_network_num_packets(SOURCE_DATA_WIDTH, PACKET_DATA_WIDTH);
    localparam int BUF_WIDTH   = NUM_PACKETS * PACKET_DATA_WIDTH;
    localparam int CNT_WIDTH   = bp_network_count_width(NUM_PACKETS);

    `BP_NETWORK_FLIT_S(DEST_ID_WIDTH, PACKET_DATA_WIDTH);

    generate
        if (PACKET_DATA_WIDTH <= 0) begin : g_bad_packet_width
            $error("bp_network_serializer: PACKET_DATA_WIDTH must be > 0");
        end
        if (SOURCE_DATA_WIDTH <= 0) begin : g_bad_source_width
            $error("bp_network_serializer: SOURCE_DATA_WIDTH must be > 0");
        end
    endgenerate

    bp_network_serializer_state_e r_state;
    logic                         r_valid;
    logic [DEST_ID_WIDTH-1:0]     r_dest_id;
    logic [BUF_WIDTH-1:0]         r_buf;
    logic [CNT_WIDTH-1:0]         w_count;
    logic                         w_last;
    logic                         w_send;
    logic                         w_accept;
    logic                         w_ready;
    bp_network_flit_s             w_flit;

    generate
        if (NUM_PACKETS == 1) begin : g_single_flit
            assign w_last = 1'b1;
        end else begin : g_multi_flit
            localparam logic [CNT_WIDTH-1:0] c_last_idx = CNT_WIDTH'(NUM_PACKETS - 1);
            assign w_last = (w_count == c_last_idx);
        end
    endgenerate

    // Ready may rise combinationally from ready_i while the last flit drains,
    // which is what lets back-to-back messages stream without a bubble.
    assign w_ready  = ~reset_i & ((r_state == eIdle) |
                                  ((r_state == eSend) & w_last & bus.ready_i));
    assign w_accept = bus.v_i & w_ready;
    assign w_send   = r_valid & bus.ready_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= eIdle;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                eIdle: begin
                    if (w_accept) begin
                        r_state <= eSend;
                        r_valid <= 1'b1;
                    end
                end
                eSend: begin
                    if (w_send && w_last && !w_accept) begin
                        r_state <= eIdle;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= eIdle;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    // Payload buffer and destination hold no reset; they are only observed in eSend.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_buf     <= BUF_WIDTH'(bus.data_i);
            r_dest_id <= bus.dest_id_i;
        end else if (w_send) begin
            r_buf     <= r_buf >> PACKET_DATA_WIDTH;
        end
    end

    bsg_counter_clear_up #(
        .WIDTH   (CNT_WIDTH)
    ) u_flit_counter (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_clear (w_accept),
        .i_up    (w_send),
        .o_count (w_count)
    );

    assign w_flit.dest_id = r_dest_id;
    assign w_flit.data    = r_buf[PACKET_DATA_WIDTH-1:0];

    assign bus.ready_o = w_ready;
    assign bus.v_o     = r_valid;
    assign bus.data_o  = w_flit;

`ifdef BP_NETWORK_SERIALIZER_LAST_FLIT_EN
    assign bus.last_o  = r_valid & w_last;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_network_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_network_serializer
// Brief    : Self-checking bench: vector table, directed corner cases and a
//            randomized run against a flit-queue reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bp_network_serializer;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    bp_network_serializer_if #(.DEST_ID_WIDTH(4), .SOURCE_DATA_WIDTH(64), .PACKET_DATA_WIDTH(16)) bus_a ();
    bp_network_serializer_if #(.DEST_ID_WIDTH(4), .SOURCE_DATA_WIDTH(40), .PACKET_DATA_WIDTH(16)) bus_b ();

    bp_network_serializer #(
        .DEST_ID_WIDTH     (4),
        .SOURCE_DATA_WIDTH (64),
        .PACKET_DATA_WIDTH (16)
    ) dut_a (
        .clk_i   (clk),
        .reset_i (rst_a),
        .bus     (bus_a.slave)
    );

    bp_network_serializer #(
        .DEST_ID_WIDTH     (4),
        .SOURCE_DATA_WIDTH (40),
        .PACKET_DATA_WIDTH (16)
    ) dut_b (
        .clk_i   (clk),
        .reset_i (rst_b),
        .bus     (bus_b.slave)
    );

    typedef struct {
        logic        v;
        logic [3:0]  dest;
        logic [63:0] data;
        logic        rdy;
        logic        exp_v;
        logic [19:0] exp_flit;
        logic        exp_rdy;
        logic        exp_last;
    } vec_t;

    vec_t vecs[22];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] d, input logic [63:0] dat,
                                input logic r, input logic ev, input logic [19:0] ef,
                                input logic er, input logic el);
        vec_t t;
        t.v = v; t.dest = d; t.data = dat; t.rdy = r;
        t.exp_v = ev; t.exp_flit = ef; t.exp_rdy = er; t.exp_last = el;
        return t;
    endfunction

    function automatic logic [19:0] chunk_flit(input logic [3:0] d, input logic [63:0] dat, input int k);
        logic [63:0] sh;
        sh = dat >> (16 * k);
        return {d, sh[15:0]};
    endfunction

    task automatic drive_a(input logic v, input logic [3:0] d, input logic [63:0] dat, input logic r);
        bus_a.v_i = v; bus_a.dest_id_i = d; bus_a.data_i = dat; bus_a.ready_i = r;
    endtask

    task automatic check_a(input string tag, input logic ev, input logic [19:0] ef,
                           input logic er, input logic el);
        check({tag, " ready_o"}, 64'(bus_a.ready_o), 64'(er));
        check({tag, " v_o"}, 64'(bus_a.v_o), 64'(ev));
        if (ev) check({tag, " data_o"}, 64'(bus_a.data_o), 64'(ef));
`ifdef BP_NETWORK_SERIALIZER_LAST_FLIT_EN
        check({tag, " last_o"}, 64'(bus_a.last_o), 64'(el));
`else
        if (el && !ev) $display("note: last without valid in %s", tag);
`endif
    endtask

    localparam logic [63:0] D1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] D2 = 64'h8888_7777_6666_5555;

    initial begin
        logic [19:0] q[$];
        int          rem;
        logic        rv, rr, ev, er;
        logic [3:0]  rd;
        logic [63:0] rdat;
        logic [39:0] pad_data;

        vecs[0]  = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b0, 20'h0,     1'b1, 1'b0);
        vecs[1]  = mk(1'b1, 4'h3, D1,    1'b1, 1'b0, 20'h0,     1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 20'h31111, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 20'h32222, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 20'h33333, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 20'h34444, 1'b1, 1'b1);
        vecs[6]  = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b0, 20'h0,     1'b1, 1'b0);
        vecs[7]  = mk(1'b1, 4'h3, D1,    1'b1, 1'b0, 20'h0,     1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 20'h31111, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 4'h0, 64'h0, 1'b0, 1'b1, 20'h32222, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 4'h0, 64'h0, 1'b0, 1'b1, 20'h32222, 1'b0, 1'b0);
        vecs[11] = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 20'h32222, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 4'h0, 64'h0, 1'b0, 1'b1, 20'h33333, 1'b0, 1'b0);
        vecs[13] = mk(1'b0, 4'h0, 64'h0, 1'b0, 1'b1, 20'h33333, 1'b0, 1'b0);
        vecs[14] = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 20'h33333, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 4'h0, 64'h0, 1'b0, 1'b1, 20'h34444, 1'b0, 1'b1);
        vecs[16] = mk(1'b1, 4'h9, D2,    1'b1, 1'b1, 20'h34444, 1'b1, 1'b1);
        vecs[17] = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 20'h95555, 1'b0, 1'b0);
        vecs[18] = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 20'h96666, 1'b0, 1'b0);
        vecs[19] = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 20'h97777, 1'b0, 1'b0);
        vecs[20] = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b1, 20'h98888, 1'b1, 1'b1);
        vecs[21] = mk(1'b0, 4'h0, 64'h0, 1'b1, 1'b0, 20'h0,     1'b1, 1'b0);

        // reset
        rst_a = 1'b1; rst_b = 1'b1;
        drive_a(1'b0, 4'h0, 64'h0, 1'b1);
        bus_b.v_i = 1'b0; bus_b.dest_id_i = 4'h0; bus_b.data_i = 40'h0; bus_b.ready_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_a("reset", 1'b0, 20'h0, 1'b0, 1'b0);
        check("reset b ready_o", 64'(bus_b.ready_o), 64'h0);
        @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check_a("post-reset idle", 1'b0, 20'h0, 1'b1, 1'b0);

        // vector table: basic, back-pressure, back-to-back
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            drive_a(vecs[i].v, vecs[i].dest, vecs[i].data, vecs[i].rdy);
            #1;
            check_a($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_flit,
                    vecs[i].exp_rdy, vecs[i].exp_last);
        end
        drive_a(1'b0, 4'h0, 64'h0, 1'b1);

        // padding: 40-bit payload in three 16-bit flits
        pad_data = 40'hAB_CDEF_1234;
        @(negedge clk);
        bus_b.v_i = 1'b1; bus_b.dest_id_i = 4'h5; bus_b.data_i = pad_data; bus_b.ready_i = 1'b1;
        #1;
        check("pad accept ready_o", 64'(bus_b.ready_o), 64'h1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus_b.v_i = 1'b0;
            #1;
            check($sformatf("pad flit%0d v_o", k), 64'(bus_b.v_o), 64'h1);
            check($sformatf("pad flit%0d data_o", k), 64'(bus_b.data_o),
                  64'(chunk_flit(4'h5, 64'(pad_data), k)));
        end
        @(negedge clk);
        #1;
        check("pad done v_o", 64'(bus_b.v_o), 64'h0);

        // reset in the middle of a message
        @(negedge clk);
        drive_a(1'b1, 4'h2, 64'h0123_4567_89AB_CDEF, 1'b1);
        #1;
        check("midrst accept ready_o", 64'(bus_a.ready_o), 64'h1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive_a(1'b0, 4'h0, 64'h0, 1'b1);
            #1;
            check_a($sformatf("midrst flit%0d", k), 1'b1,
                    chunk_flit(4'h2, 64'h0123_4567_89AB_CDEF, k), 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_a = 1'b1;
        #1;
        check("midrst ready gated", 64'(bus_a.ready_o), 64'h0);
        @(negedge clk);
        #1;
        check_a("midrst in reset", 1'b0, 20'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check_a("midrst released", 1'b0, 20'h0, 1'b1, 1'b0);
        @(negedge clk);
        drive_a(1'b1, 4'h7, 64'h000D_000C_000B_000A, 1'b1);
        #1;
        check("midrst new accept", 64'(bus_a.ready_o), 64'h1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_a(1'b0, 4'h0, 64'h0, 1'b1);
            #1;
            check_a($sformatf("midrst new flit%0d", k), 1'b1,
                    chunk_flit(4'h7, 64'h000D_000C_000B_000A, k), (k == 3), (k == 3));
        end
        @(negedge clk);
        #1;
        check_a("midrst new done", 1'b0, 20'h0, 1'b1, 1'b0);

        // randomized traffic against a queue-of-flits model
        rem = 0;
        q.delete();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            rv   = 1'($urandom_range(0, 1));
            rd   = 4'($urandom);
            rdat = {$urandom, $urandom};
            rr   = ($urandom_range(0, 3) != 0);
            drive_a(rv, rd, rdat, rr);
            #1;
            ev = (rem > 0);
            er = (rem == 0) || ((rem == 1) && rr);
            check_a($sformatf("rand%0d", c), ev, (q.size() > 0) ? q[0] : 20'h0, er,
                    ev && (rem == 1));
            if (ev && rr) begin
                void'(q.pop_front());
                rem--;
            end
            if (rv && er) begin
                for (int k = 0; k < 4; k++) q.push_back(chunk_flit(rd, rdat, k));
                rem = 4;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bp_network_serializer.md
# bp_network_serializer

Splits one wide network message (destination ID plus payload) into a fixed-length train of narrow flits, each tagged with the destination ID, and streams them onto the on-chip network. Sits directly upstream of `bp_network_deserializer`: its output flit stream is exactly the deserializer's input format. It buffers one message at a time and back-pressures the source until the last flit is accepted.

## Interface
Parameters:
- `dest_id_width_p`, "inv": destination ID width.
- `source_data_width_p`, "inv": message payload width.
- `packet_data_width_p`, "inv": payload bits per flit.
- `num_packets_lp`, derived as ceil(`source_data_width_p` / `packet_data_width_p`): flits per message.
- `flit_width_lp`, derived as `packet_data_width_p` + `dest_id_width_p`: flit width.

Ports:
- `clk_i`, input, 1: the single clock.
- `reset_i`, input, 1: synchronous, active-high reset.
- `v_i`, input, 1: message valid.
- `ready_o`, output, 1: the block can accept a message.
- `dest_id_i`, input, `dest_id_width_p`: message destination.
- `data_i`, input, `source_data_width_p`: message payload.
- `v_o`, output, 1: flit valid.
- `data_o`, output, `flit_width_lp`: flit, packed as {dest_id, chunk}.
- `ready_i`, input, 1: downstream accepts the flit.
- `last_o`, output, 1: the current flit is the final flit of its message. Present only with the macro below.

## Operation
- Two-state FSM:
  - eIdle: `ready_o`=1, `v_o`=0.
  - eSend: `v_o`=1.
- A message is accepted when `v_i` and `ready_o` are both high in the same cycle:
  - latch `dest_id_i`;
  - latch `data_i`, zero-extended to `num_packets_lp`*`packet_data_width_p`, into the shift buffer;
  - clear the flit counter;
  - go to eSend.
- In eSend, `data_o` = {latched dest_id, buffer[`packet_data_width_p`-1:0]}. Flits go out least significant chunk first.
- A flit is sent when `v_o` and `ready_i` are both high:
  - shift the buffer right by `packet_data_width_p`;
  - increment the counter.
- Last flit: counter == `num_packets_lp`-1.
  - When it is sent, return to eIdle, unless a new message is accepted in the same cycle. In that case, reload the buffer, dest_id and counter, and stay in eSend.
- `ready_o` = (state==eIdle) | (state==eSend & last & `ready_i`). This is a combinational path from `ready_i` to `ready_o`, and it is allowed.
- Output handshake rules:
  - once `v_o` rises, `v_o` and `data_o` hold stable until `ready_i`;
  - `v_o` never depends on `ready_i`.
- Special widths:
  - `num_packets_lp`==1: every flit is the last flit.
  - Counter width is max(1, $clog2(`num_packets_lp`)).
- Parameter checks: `packet_data_width_p` > 0 and `source_data_width_p` > 0 are required. Elaboration error otherwise.

## Timing
- Reset values, held while `reset_i`=1: state eIdle, `v_o`=0, `ready_o`=0, counter 0, `last_o`=0. Buffer contents are don't-care.
- Reset mid-message: the partially sent message is dropped. No further flits of it appear.
- Latency: a message accepted on cycle N produces its first flit with `v_o`=1 on cycle N+1.
- Throughput: one flit per cycle with `ready_i` held high. Back-to-back messages leave no bubble.
- Stalls (`ready_i`=0) freeze the state, counter and buffer.

## Configuration
- `BP_NETWORK_SERIALIZER_LAST_FLIT_EN`:
  - defined: the `last_o` port exists and equals `v_o` & (counter == `num_packets_lp`-1);
  - undefined: the port and its logic are absent. Flit behaviour is otherwise identical.

## Structure
- `bp_network_pkg` holds:
  - the flit struct macro `bp_network_flit_s` ({dest_id, data});
  - the state enum `bp_network_serializer_state_e` {eIdle, eSend};
  - a shared function computing `num_packets_lp`, so that serializer and deserializer always agree.
- Sub-module: `bsg_counter_clear_up` for the flit counter. Clear on accept, up on flit send.
- The buffer and dest_id register are in-module enabled flops.

## Test plan
Default configuration for all scenarios: dest 4b, source 64b, packet 16b, so 4 flits.
- Reset then idle: after `reset_i` falls, `ready_o`=1 and `v_o`=0 until `v_i`.
- Basic message: dest=0x3, data=0x4444_3333_2222_1111, `ready_i`=1.
  - `data_o` is 0x31111, 0x32222, 0x33333, 0x34444 on cycles N+1..N+4.
  - `v_o`=0 on N+5.
- Back-pressure: same message with `ready_i` toggling 1,0,0,1,…; each flit is held stable while stalled; 4 flits total, in order.
- Back-to-back: second message (dest=0x9) presented on the last-flit cycle. It is accepted that cycle, and its first flit (0x9xxxx) appears the next cycle with no bubble.
- Padding: source 40b, packet 16b (3 flits), data=0xAB_CDEF_1234. Flits 0x1234, 0xCDEF, 0x00AB, each with dest prepended.
- Reset mid-message: assert `reset_i` after flit 2. `v_o`=0 the next cycle, and the next message starts from chunk 0. With the macro defined, check `last_o` pulses only on flit 4.
